// File: rtl/dram_line_mngr_pkg.sv
// rtl/dram_line_mngr_pkg.sv - shared types and constants for the DRAM line manager
// Contents:
//   state_t     : FSM state encoding ST_IDLE..ST_DONE (3 bits)
//   BEATS/BEAT_W: burst length and beat-index width
//   ATOP_NONE   : plain (non-atomic) write attribute
//   LINE_W/WORD_W: cache-line and bus-word widths
//   line_word() : selects one bus word out of a line
package dram_line_mngr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;

  localparam logic [5:0] ATOP_NONE = 6'd0;

  // Word 0 sits in the least significant bits of the line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [BEAT_W-1:0] idx);
    return line[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dram_line_mngr_if.sv
// rtl/dram_line_mngr_if.sv - DRAM bus write/read channels between manager and subordinate
// Channels:
//   AW : awvalid/awready, awid, awaddr, awatop
//   W  : wvalid/wready, wdata, wlast
//   B  : bvalid/bready, bid, bcomp
//   AR : arvalid/arready, arid, araddr
//   R  : rvalid/rready, rid, rdata, rlast
// Modports: master (line manager side), slave (DRAM subordinate side).
interface dram_line_mngr_if;
  import dram_line_mngr_pkg::*;

  logic              awvalid;
  logic              awready;
  logic [3:0]        awid;
  logic [31:0]       awaddr;
  logic [5:0]        awatop;

  logic              wvalid;
  logic              wready;
  logic [WORD_W-1:0] wdata;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [3:0]        bid;
  logic              bcomp;

  logic              arvalid;
  logic              arready;
  logic [3:0]        arid;
  logic [31:0]       araddr;

  logic              rvalid;
  logic              rready;
  logic [3:0]        rid;
  logic [WORD_W-1:0] rdata;
  logic              rlast;

  modport master (
    output awvalid, awid, awaddr, awatop,
    input  awready,
    output wvalid, wdata, wlast,
    input  wready,
    input  bvalid, bid, bcomp,
    output bready,
    output arvalid, arid, araddr,
    input  arready,
    input  rvalid, rid, rdata, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awatop,
    output awready,
    input  wvalid, wdata, wlast,
    output wready,
    output bvalid, bid, bcomp,
    input  bready,
    input  arvalid, arid, araddr,
    output arready,
    output rvalid, rid, rdata, rlast,
    input  rready
  );

endinterface

// File: rtl/dram_line_mngr.sv
// rtl/dram_line_mngr.sv - converts 128-bit line requests into 4-beat DRAM bus bursts
// Ports:
//   clk, rst_n          : bus clock, asynchronous active-low reset
//   req_valid/req_ready : client line request handshake (ready only in IDLE)
//   req_we, req_addr    : 1=write line / 0=read line, byte address (bits [3:0] ignored)
//   req_wdata           : write line, word0 in [31:0]
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : last read line, held until the next read completes
//   resp_err            : error status, valid with resp_valid
//   bus                 : DRAM bus, master modport of dram_line_mngr_if
// Parameters: MID (bus ID), TO_CYCLES (response timeout limit).
// Optional feature: DRAM_MNGR_TIMEOUT_EN adds a B/R response timeout.
module dram_line_mngr
  import dram_line_mngr_pkg::*;
#(
  parameter logic [3:0] MID       = 4'd0,
  parameter int         TO_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              resp_err,
  dram_line_mngr_if.master  bus
);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [31:0]         addr_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   rdata_q;
  logic [3:0]          id_q;
  logic                err_q;
  // Holds req_ready low while rst_n is asserted and until the first clock after release.
  logic                live_q;
  logic                last_beat;
  logic                to_hit;
  logic                unused_addr_bits;

  assign last_beat        = (beat_q == 2'd3);
  assign unused_addr_bits = ^req_addr[3:0];

`ifdef DRAM_MNGR_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_q;
  logic            in_resp;

  assign in_resp = (state_q == ST_B) || (state_q == ST_R);
  assign to_hit  = in_resp && (to_cnt_q == TO_W'(TO_CYCLES - 1));

  // Counts idle response cycles; any R beat restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (!in_resp || ((state_q == ST_R) && bus.rvalid)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  logic unused_to;
  assign unused_to = (TO_CYCLES > 0);
  assign to_hit    = 1'b0;
`endif

  // Payload outputs come straight from registers, so they stay stable while valid waits.
  assign bus.awid    = id_q;
  assign bus.awaddr  = addr_q;
  assign bus.awatop  = ATOP_NONE;
  assign bus.wdata   = line_word(line_q, beat_q);
  assign bus.wlast   = (state_q == ST_W) && last_beat;
  assign bus.arid    = id_q;
  assign bus.araddr  = addr_q;
  assign resp_rdata  = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = live_q;
        if (req_valid && live_q) begin
          state_d = req_we ? ST_AW : ST_AR;
        end
      end
      ST_AW: begin
        bus.awvalid = 1'b1;
        if (bus.awready) state_d = ST_W;
      end
      ST_W: begin
        bus.wvalid = 1'b1;
        if (bus.wready && last_beat) state_d = ST_B;
      end
      ST_B: begin
        bus.bready = 1'b1;
        if (bus.bvalid || to_hit) state_d = ST_DONE;
      end
      ST_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_d = ST_R;
      end
      ST_R: begin
        bus.rready = 1'b1;
        // A beat arriving on the limit cycle still counts; the timeout only fires when idle.
        if (bus.rvalid ? last_beat : to_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && live_q) begin
            addr_q <= {req_addr[31:4], 4'b0};
            // Reads start from an all-zero line so a timed-out read returns zeros
            // in the words that never arrived.
            line_q <= req_we ? req_wdata : '0;
            id_q   <= MID;
            err_q  <= 1'b0;
            beat_q <= '0;
          end
        end
        ST_W: begin
          if (bus.wready) beat_q <= beat_q + 2'd1;
        end
        ST_B: begin
          if (bus.bvalid) begin
            if ((bus.bid != MID) || !bus.bcomp) err_q <= 1'b1;
          end else if (to_hit) begin
            err_q <= 1'b1;
          end
        end
        ST_R: begin
          if (bus.rvalid) begin
            line_q[beat_q*WORD_W +: WORD_W] <= bus.rdata;
            beat_q <= beat_q + 2'd1;
            if ((bus.rid != MID) || (bus.rlast != last_beat)) err_q <= 1'b1;
            // Publish the assembled line on the final beat so it is visible during DONE.
            if (last_beat) rdata_q <= {bus.rdata, line_q[LINE_W-WORD_W-1:0]};
          end else if (to_hit) begin
            err_q   <= 1'b1;
            rdata_q <= line_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
